rally_velocity_ctrl: RTL and testbench

Ball-velocity controller for the Pong game core; it replaces the single-shot hit mapper. It converts paddle-hit offsets into horizontal and vertical ball speeds through a two-stage registered datapath, and adds a per-rally speed-up bonus. A serve/rally state machine holds the ball for a programmable number of frames after every miss. It sits between the collision detector (hit, hit offset, miss) and the square-motion block, which consumes `sq_xvel`, `sq_yvel`, `yvel_up` and `serving`.

---
 rtl/pong_pkg.sv | 17 +
 rtl/vel_scale_pipe.sv | 85 ++++++++
 rtl/rally_velocity_ctrl.sv | 132 +++++++++++++
 tb/tb_rally_velocity_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong core definitions: rally state encoding, rally counter width and
// the serve-slope helper used to derive the serve vertical speed.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        RALLY = 2'd2
    } rally_state_t;

    localparam int RALLY_W = 8;

    function automatic int serve_yvel(input int init);
        return init * 5 / 6;
    endfunction

endpackage

// File: rtl/vel_scale_pipe.sv
// Hit-offset clamp, rally bonus and velocity scale/saturate datapath.
// The rally bonus is only built when RALLY_SPEEDUP_EN is defined.
module vel_scale_pipe
    import pong_pkg::*;
#(
    parameter int HIT_W        = 7,
    parameter int PDL_HALF     = 48,
    parameter int MIN_XVEL     = 500,
    parameter int MAX_XVEL     = 600,
    parameter int SPEEDUP_STEP = 20,
    parameter int SPEEDUP_CAP  = 200,
    parameter int VEL_WIDTH    = 10
) (
    input  logic                 clk_0,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 hit_valid,
    input  logic [HIT_W-1:0]     hit_y,
    input  logic                 hit_above,
    input  logic [RALLY_W-1:0]   rally_cnt,
    output logic                 busy,
    output logic                 res_valid,
    output logic [VEL_WIDTH-1:0] res_xvel,
    output logic [VEL_WIDTH-1:0] res_yvel,
    output logic                 res_up
);

    localparam int AW         = VEL_WIDTH + 2;
    localparam int SCALE_VELX = (MAX_XVEL - MIN_XVEL) / PDL_HALF;
    localparam int SCALE_VELY = MAX_XVEL / PDL_HALF;

    logic [HIT_W-1:0] hy;
    logic [AW-1:0]    bonus;
    logic             s1_valid;
    logic [HIT_W-1:0] s1_hy;
    logic [AW-1:0]    s1_bonus;
    logic             s1_up;
    logic [AW-1:0]    x_sum;
    logic [AW-1:0]    y_sum;

    assign hy = (hit_y > HIT_W'(PDL_HALF)) ? HIT_W'(PDL_HALF) : hit_y;

`ifdef RALLY_SPEEDUP_EN
    // Product width covers the largest rally count times the step, so the cap compare never wraps.
    localparam int PW = RALLY_W + $clog2(SPEEDUP_STEP + 1);
    logic [PW-1:0] bonus_prod;

    always_comb begin
        bonus_prod = PW'(rally_cnt) * PW'(SPEEDUP_STEP);
        bonus      = (bonus_prod > PW'(SPEEDUP_CAP)) ? AW'(SPEEDUP_CAP) : AW'(bonus_prod);
    end
`else
    localparam int unused_bonus_cfg = SPEEDUP_STEP + SPEEDUP_CAP;
    logic unused_rally_cnt;
    assign unused_rally_cnt = ^rally_cnt;
    assign bonus = '0;
`endif

    always_ff @(posedge clk_0) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_hy    <= '0;
            s1_bonus <= '0;
            s1_up    <= 1'b0;
        end else begin
            s1_valid <= hit_valid && !flush;
            if (hit_valid) begin
                s1_hy    <= hy;
                s1_bonus <= bonus;
                s1_up    <= hit_above;
            end
        end
    end

    always_comb begin
        x_sum     = AW'(MIN_XVEL) + AW'(SCALE_VELX) * AW'(s1_hy) + s1_bonus;
        y_sum     = AW'(SCALE_VELY) * AW'(s1_hy);
        res_xvel  = (|x_sum[AW-1:VEL_WIDTH]) ? '1 : x_sum[VEL_WIDTH-1:0];
        res_yvel  = (|y_sum[AW-1:VEL_WIDTH]) ? '1 : y_sum[VEL_WIDTH-1:0];
        res_up    = s1_up;
        res_valid = s1_valid;
        busy      = s1_valid;
    end

endmodule

// File: rtl/rally_velocity_ctrl.sv
// Pong ball-velocity controller: serve/rally FSM, serve and rally counters, and the
// registered output stage of the hit pipeline. Optional bonus: RALLY_SPEEDUP_EN.
module rally_velocity_ctrl
    import pong_pkg::*;
#(
    parameter int INIT_XVEL    = 300,
    parameter int MIN_XVEL     = 500,
    parameter int MAX_XVEL     = 600,
    parameter int PDL_HALF     = 48,
    parameter int HIT_W        = 7,
    parameter int SPEEDUP_STEP = 20,
    parameter int SPEEDUP_CAP  = 200,
    parameter int SERVE_FRAMES = 60,
    parameter int VEL_WIDTH    = $clog2(MAX_XVEL + SPEEDUP_CAP + 1)
) (
    input  logic                 clk_0,
    input  logic                 rst,
    input  logic                 frame_tick,
    input  logic                 paddle_hit,
    input  logic [HIT_W-1:0]     hit_y,
    input  logic                 hit_above,
    input  logic                 sq_missed,
    input  logic                 game_over,
    input  logic                 game_startup,
    output logic [VEL_WIDTH-1:0] sq_xvel,
    output logic [VEL_WIDTH-1:0] sq_yvel,
    output logic                 yvel_up,
    output logic                 serving,
    output logic                 vel_valid,
    output logic [RALLY_W-1:0]   rally_cnt
);

    localparam int SERVE_YVEL = serve_yvel(INIT_XVEL);
    localparam int CW         = $clog2(SERVE_FRAMES + 1);

    rally_state_t         state;
    rally_state_t         next_state;
    logic [CW-1:0]        serve_cnt;
    logic                 mode_hold;
    logic                 miss_event;
    logic                 flush;
    logic                 hit_accept;
    logic                 busy;
    logic                 res_valid;
    logic [VEL_WIDTH-1:0] res_xvel;
    logic [VEL_WIDTH-1:0] res_yvel;
    logic                 res_up;

    assign mode_hold = game_over || game_startup;

    always_ff @(posedge clk_0) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (mode_hold) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = SERVE;
                SERVE:   if (frame_tick && serve_cnt == CW'(SERVE_FRAMES - 1)) next_state = RALLY;
                RALLY:   if (sq_missed) next_state = SERVE;
                default: next_state = IDLE;
            endcase
        end
    end

    // A miss outranks a same-cycle hit, and both lose to a mode change.
    always_comb begin
        serving    = (state != RALLY);
        miss_event = (state == RALLY) && sq_missed && !mode_hold;
        flush      = mode_hold || miss_event;
        hit_accept = paddle_hit && (state == RALLY) && !flush && !busy;
    end

    always_ff @(posedge clk_0) begin
        if (!rst)                serve_cnt <= '0;
        else if (state != SERVE) serve_cnt <= '0;
        else if (frame_tick)     serve_cnt <= serve_cnt + 1'b1;
    end

    vel_scale_pipe #(
        .HIT_W        (HIT_W),
        .PDL_HALF     (PDL_HALF),
        .MIN_XVEL     (MIN_XVEL),
        .MAX_XVEL     (MAX_XVEL),
        .SPEEDUP_STEP (SPEEDUP_STEP),
        .SPEEDUP_CAP  (SPEEDUP_CAP),
        .VEL_WIDTH    (VEL_WIDTH)
    ) u_pipe (
        .clk_0     (clk_0),
        .rst       (rst),
        .flush     (flush),
        .hit_valid (hit_accept),
        .hit_y     (hit_y),
        .hit_above (hit_above),
        .rally_cnt (rally_cnt),
        .busy      (busy),
        .res_valid (res_valid),
        .res_xvel  (res_xvel),
        .res_yvel  (res_yvel),
        .res_up    (res_up)
    );

    // Second pipeline stage: serve loads win over a completing hit.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            sq_xvel   <= VEL_WIDTH'(INIT_XVEL);
            sq_yvel   <= VEL_WIDTH'(SERVE_YVEL);
            yvel_up   <= 1'b0;
            vel_valid <= 1'b0;
            rally_cnt <= '0;
        end else begin
            vel_valid <= 1'b0;
            if (flush) begin
                sq_xvel <= VEL_WIDTH'(INIT_XVEL);
                sq_yvel <= VEL_WIDTH'(SERVE_YVEL);
                yvel_up <= 1'b0;
                if (miss_event) rally_cnt <= '0;
            end else if (res_valid) begin
                sq_xvel   <= res_xvel;
                sq_yvel   <= res_yvel;
                yvel_up   <= res_up;
                vel_valid <= 1'b1;
                if (rally_cnt != '1) rally_cnt <= rally_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rally_velocity_ctrl.sv
// Directed bench for rally_velocity_ctrl: serve, rally hits, bonus cap, misses,
// mode changes, reset and output saturation on a second, overridden instance.
module tb_rally_velocity_ctrl;

`ifdef RALLY_SPEEDUP_EN
    localparam bit BONUS_ON = 1'b1;
`else
    localparam bit BONUS_ON = 1'b0;
`endif

    logic       clk_0 = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       paddle_hit;
    logic [6:0] hit_y;
    logic       hit_above;
    logic       sq_missed;
    logic       game_over;
    logic       game_startup;

    logic [9:0] sq_xvel, sq_yvel, sat_xvel, sat_yvel;
    logic       yvel_up, serving, vel_valid;
    logic       sat_up, sat_serving, sat_valid;
    logic [7:0] rally_cnt, sat_rally_cnt;

    int checks = 0;
    int passes = 0;

    always #5 clk_0 = ~clk_0;

    rally_velocity_ctrl dut (
        .clk_0(clk_0), .rst(rst), .frame_tick(frame_tick), .paddle_hit(paddle_hit),
        .hit_y(hit_y), .hit_above(hit_above), .sq_missed(sq_missed),
        .game_over(game_over), .game_startup(game_startup),
        .sq_xvel(sq_xvel), .sq_yvel(sq_yvel), .yvel_up(yvel_up), .serving(serving),
        .vel_valid(vel_valid), .rally_cnt(rally_cnt)
    );

    rally_velocity_ctrl #(.MIN_XVEL(950), .MAX_XVEL(1050), .VEL_WIDTH(10)) dut_sat (
        .clk_0(clk_0), .rst(rst), .frame_tick(frame_tick), .paddle_hit(paddle_hit),
        .hit_y(hit_y), .hit_above(hit_above), .sq_missed(sq_missed),
        .game_over(game_over), .game_startup(game_startup),
        .sq_xvel(sat_xvel), .sq_yvel(sat_yvel), .yvel_up(sat_up), .serving(sat_serving),
        .vel_valid(sat_valid), .rally_cnt(sat_rally_cnt)
    );

    task automatic tick();
        @(posedge clk_0);
        #1;
    endtask

    task automatic do_hit(input logic [6:0] y, input logic above);
        paddle_hit = 1'b1; hit_y = y; hit_above = above;
        tick();
        paddle_hit = 1'b0;
        tick();
    endtask

    task automatic serve_ball();
        for (int i = 0; i < 60; i++) begin
            frame_tick = 1'b1; tick();
            frame_tick = 1'b0; tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        checks++; if (sq_xvel !== 10'd300) $display("[TB] FAIL reset_xvel: got %0d expected 300", sq_xvel); else passes++;
        checks++; if (sq_yvel !== 10'd250) $display("[TB] FAIL reset_yvel: got %0d expected 250", sq_yvel); else passes++;
        checks++; if (serving !== 1'b1) $display("[TB] FAIL reset_serving: got %0b expected 1", serving); else passes++;
        checks++; if (rally_cnt !== 8'd0) $display("[TB] FAIL reset_rally_cnt: got %0d expected 0", rally_cnt); else passes++;
        checks++; if (vel_valid !== 1'b0 || yvel_up !== 1'b0) $display("[TB] FAIL reset_valid_up: got %0b%0b expected 00", vel_valid, yvel_up); else passes++;
        rst = 1'b1;
        tick();
        checks++; if (serving !== 1'b1) $display("[TB] FAIL startup_hold: got %0b expected 1", serving); else passes++;
    endtask

    task automatic test_serve_to_rally();
        game_startup = 1'b0;
        tick();
        paddle_hit = 1'b1; hit_y = 7'd0;
        tick();
        paddle_hit = 1'b0;
        tick();
        checks++; if (vel_valid !== 1'b0) $display("[TB] FAIL serve_hit_dropped_a: got %0b expected 0", vel_valid); else passes++;
        tick();
        checks++; if (vel_valid !== 1'b0 || sq_xvel !== 10'd300) $display("[TB] FAIL serve_hit_dropped_b: got %0b/%0d expected 0/300", vel_valid, sq_xvel); else passes++;
        for (int i = 0; i < 60; i++) begin
            frame_tick = 1'b1; tick();
            if (i == 58) begin
                checks++; if (serving !== 1'b1) $display("[TB] FAIL serving_after_59: got %0b expected 1", serving); else passes++;
            end
            if (i == 59) begin
                checks++; if (serving !== 1'b0) $display("[TB] FAIL serving_after_60: got %0b expected 0", serving); else passes++;
            end
            frame_tick = 1'b0; tick();
        end
    endtask

    task automatic test_first_hit();
        do_hit(7'd0, 1'b0);
        checks++; if (vel_valid !== 1'b1) $display("[TB] FAIL hit0_valid: got %0b expected 1", vel_valid); else passes++;
        checks++; if (sq_xvel !== 10'd500 || sq_yvel !== 10'd0) $display("[TB] FAIL hit0_vel: got %0d/%0d expected 500/0", sq_xvel, sq_yvel); else passes++;
        checks++; if (rally_cnt !== 8'd1) $display("[TB] FAIL hit0_cnt: got %0d expected 1", rally_cnt); else passes++;
        checks++; if (sat_xvel !== 10'd950) $display("[TB] FAIL sat_hit0_x: got %0d expected 950", sat_xvel); else passes++;
        do_hit(7'd100, 1'b1);
        checks++; if (sq_xvel !== (BONUS_ON ? 10'd616 : 10'd596)) $display("[TB] FAIL hit1_x: got %0d expected %0d", sq_xvel, BONUS_ON ? 616 : 596); else passes++;
        checks++; if (sq_yvel !== 10'd576 || yvel_up !== 1'b1) $display("[TB] FAIL hit1_y: got %0d/%0b expected 576/1", sq_yvel, yvel_up); else passes++;
        checks++; if (rally_cnt !== 8'd2) $display("[TB] FAIL hit1_cnt: got %0d expected 2", rally_cnt); else passes++;
        checks++; if (sat_xvel !== 10'd1023 || sat_yvel !== 10'd1008) $display("[TB] FAIL sat_hit1: got %0d/%0d expected 1023/1008", sat_xvel, sat_yvel); else passes++;
    endtask

    task automatic test_back_to_back();
        paddle_hit = 1'b1; hit_y = 7'd10; hit_above = 1'b0;
        tick();
        hit_y = 7'd20;
        checks++; if (vel_valid !== 1'b0) $display("[TB] FAIL b2b_n1_valid: got %0b expected 0", vel_valid); else passes++;
        tick();
        hit_y = 7'd30;
        checks++; if (vel_valid !== 1'b1 || sq_xvel !== (BONUS_ON ? 10'd560 : 10'd520)) $display("[TB] FAIL b2b_first: got %0b/%0d expected 1/%0d", vel_valid, sq_xvel, BONUS_ON ? 560 : 520); else passes++;
        checks++; if (sq_yvel !== 10'd120) $display("[TB] FAIL b2b_first_y: got %0d expected 120", sq_yvel); else passes++;
        tick();
        paddle_hit = 1'b0;
        checks++; if (vel_valid !== 1'b0 || sq_xvel !== (BONUS_ON ? 10'd560 : 10'd520)) $display("[TB] FAIL b2b_hold: got %0b/%0d expected 0/%0d", vel_valid, sq_xvel, BONUS_ON ? 560 : 520); else passes++;
        tick();
        checks++; if (vel_valid !== 1'b1 || sq_xvel !== (BONUS_ON ? 10'd620 : 10'd560)) $display("[TB] FAIL b2b_second: got %0b/%0d expected 1/%0d", vel_valid, sq_xvel, BONUS_ON ? 620 : 560); else passes++;
        checks++; if (sq_yvel !== 10'd360 || rally_cnt !== 8'd4) $display("[TB] FAIL b2b_second_y_cnt: got %0d/%0d expected 360/4", sq_yvel, rally_cnt); else passes++;
    endtask

    task automatic test_bonus_cap();
        int exp_x;
        for (int pre = 4; pre < 12; pre++) begin
            do_hit(7'd48, 1'b0);
            exp_x = 596 + (BONUS_ON ? ((pre * 20 > 200) ? 200 : pre * 20) : 0);
            checks++; if (vel_valid !== 1'b1 || int'(sq_xvel) != exp_x) $display("[TB] FAIL bonus_pre%0d: got %0b/%0d expected 1/%0d", pre, vel_valid, sq_xvel, exp_x); else passes++;
        end
        checks++; if (sq_xvel !== (BONUS_ON ? 10'd796 : 10'd596)) $display("[TB] FAIL bonus_final: got %0d expected %0d", sq_xvel, BONUS_ON ? 796 : 596); else passes++;
        checks++; if (rally_cnt !== 8'd12) $display("[TB] FAIL bonus_cnt: got %0d expected 12", rally_cnt); else passes++;
        checks++; if (sat_xvel !== 10'd1023 || sat_yvel !== 10'd1008) $display("[TB] FAIL sat_final: got %0d/%0d expected 1023/1008", sat_xvel, sat_yvel); else passes++;
    endtask

    task automatic test_miss_inflight();
        paddle_hit = 1'b1; hit_y = 7'd0; hit_above = 1'b1;
        tick();
        paddle_hit = 1'b0; sq_missed = 1'b1;
        checks++; if (vel_valid !== 1'b0) $display("[TB] FAIL miss_n1_valid: got %0b expected 0", vel_valid); else passes++;
        tick();
        sq_missed = 1'b0;
        checks++; if (vel_valid !== 1'b0) $display("[TB] FAIL miss_n2_valid: got %0b expected 0", vel_valid); else passes++;
        checks++; if (sq_xvel !== 10'd300 || sq_yvel !== 10'd250 || yvel_up !== 1'b0) $display("[TB] FAIL miss_serve_vel: got %0d/%0d/%0b expected 300/250/0", sq_xvel, sq_yvel, yvel_up); else passes++;
        checks++; if (rally_cnt !== 8'd0 || serving !== 1'b1) $display("[TB] FAIL miss_cnt_serving: got %0d/%0b expected 0/1", rally_cnt, serving); else passes++;
        tick();
        checks++; if (vel_valid !== 1'b0) $display("[TB] FAIL miss_n3_valid: got %0b expected 0", vel_valid); else passes++;
        for (int i = 0; i < 60; i++) begin
            frame_tick = 1'b1; tick();
            if (i == 58) begin
                checks++; if (serving !== 1'b1) $display("[TB] FAIL reserve_after_59: got %0b expected 1", serving); else passes++;
            end
            if (i == 59) begin
                checks++; if (serving !== 1'b0) $display("[TB] FAIL reserve_after_60: got %0b expected 0", serving); else passes++;
            end
            frame_tick = 1'b0; tick();
        end
    endtask

    task automatic test_miss_hit_same_cycle();
        do_hit(7'd0, 1'b0);
        checks++; if (sq_xvel !== 10'd500 || rally_cnt !== 8'd1) $display("[TB] FAIL same_pre: got %0d/%0d expected 500/1", sq_xvel, rally_cnt); else passes++;
        paddle_hit = 1'b1; sq_missed = 1'b1; hit_y = 7'd48;
        tick();
        paddle_hit = 1'b0; sq_missed = 1'b0;
        checks++; if (sq_xvel !== 10'd300 || rally_cnt !== 8'd0 || serving !== 1'b1) $display("[TB] FAIL same_miss: got %0d/%0d/%0b expected 300/0/1", sq_xvel, rally_cnt, serving); else passes++;
        tick();
        checks++; if (vel_valid !== 1'b0 || sq_xvel !== 10'd300) $display("[TB] FAIL same_no_valid: got %0b/%0d expected 0/300", vel_valid, sq_xvel); else passes++;
        serve_ball();
    endtask

    task automatic test_game_over();
        do_hit(7'd0, 1'b0);
        checks++; if (sq_xvel !== 10'd500) $display("[TB] FAIL go_pre: got %0d expected 500", sq_xvel); else passes++;
        paddle_hit = 1'b1; hit_y = 7'd48;
        tick();
        paddle_hit = 1'b0; game_over = 1'b1;
        tick();
        checks++; if (vel_valid !== 1'b0 || sq_xvel !== 10'd300 || sq_yvel !== 10'd250) $display("[TB] FAIL go_flush: got %0b/%0d/%0d expected 0/300/250", vel_valid, sq_xvel, sq_yvel); else passes++;
        checks++; if (serving !== 1'b1) $display("[TB] FAIL go_serving: got %0b expected 1", serving); else passes++;
        game_over = 1'b0;
        tick(); tick();
        checks++; if (serving !== 1'b1 || vel_valid !== 1'b0) $display("[TB] FAIL go_release: got %0b/%0b expected 1/0", serving, vel_valid); else passes++;
        serve_ball();
    endtask

    task automatic test_reset_midpipe();
        checks++; if (serving !== 1'b0) $display("[TB] FAIL rst_pre_rally: got %0b expected 0", serving); else passes++;
        paddle_hit = 1'b1; hit_y = 7'd48; hit_above = 1'b1;
        tick();
        paddle_hit = 1'b0; rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++; if (vel_valid !== 1'b0 || sq_xvel !== 10'd300 || rally_cnt !== 8'd0) $display("[TB] FAIL rst_mid: got %0b/%0d/%0d expected 0/300/0", vel_valid, sq_xvel, rally_cnt); else passes++;
        tick();
        checks++; if (vel_valid !== 1'b0 || serving !== 1'b1 || yvel_up !== 1'b0) $display("[TB] FAIL rst_after: got %0b/%0b/%0b expected 0/1/0", vel_valid, serving, yvel_up); else passes++;
    endtask

    initial begin
        rst = 1'b0; frame_tick = 1'b0; paddle_hit = 1'b0; hit_y = '0; hit_above = 1'b0;
        sq_missed = 1'b0; game_over = 1'b0; game_startup = 1'b1;
        test_reset();
        test_serve_to_rally();
        test_first_hit();
        test_back_to_back();
        test_bonus_cap();
        test_miss_inflight();
        test_miss_hit_same_cycle();
        test_game_over();
        test_reset_midpipe();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
